// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
//   UART 8N1 transmitter fed by a small byte FIFO. Bytes are accepted on a
//   valid/ready handshake, queued, and serialised LSB-first as
//   start(0), d0..d7, stop(1). Each bit lasts CLKS_PER_BIT clocks.
//
// Parameters
//   CLKS_PER_BIT  clocks per bit period (2..255, 8-bit counter)
//   FIFO_DEPTH    FIFO entries (power of 2, 2..16)
//
// Ports
//   i_Clock       system clock, rising edge
//   i_Rst_n       asynchronous active-low reset
//   i_Tx_DV       write strobe; byte accepted when i_Tx_DV & o_Tx_Ready
//   i_Tx_Byte     byte to queue, sampled on the accepting edge
//   o_Tx_Ready    FIFO not full (registered)
//   o_Tx_Serial   serial line, idle high
//   o_Tx_Active   high from first start-bit cycle to last stop-bit cycle
//   o_Tx_Done     one-cycle pulse after each stop bit
//   o_Fifo_Count  bytes currently queued (0..FIFO_DEPTH)
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic                          i_Tx_DV,
  input  logic [7:0]                    i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  localparam int            PW          = $clog2(FIFO_DEPTH);
  localparam int            CW          = PW + 1;
  localparam logic [7:0]    LP_BIT_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LP_FULL     = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } t_state;

  // ---------------- FIFO ----------------
  logic [7:0]    r_Mem [FIFO_DEPTH];
  logic [7:0]    r_Rd_Data;
  logic [PW-1:0] r_Wr_Ptr;
  logic [PW-1:0] r_Rd_Ptr;
  logic [CW-1:0] r_Count;
  logic          r_Ready;
  logic          r_Was_Nonempty;

  logic          w_Wr;
  logic          w_Pop;
  logic          w_Can_Pop;
  logic [CW-1:0] w_Count_Next;

  assign w_Wr = i_Tx_DV & r_Ready;

  // The storage array has a registered read port, so the head byte is only
  // valid one cycle after it becomes the head. A byte written into an empty
  // FIFO therefore must sit for a cycle before it can be popped.
  assign w_Can_Pop = (r_Count != '0) & r_Was_Nonempty;

  always_comb begin
    w_Count_Next = r_Count;
    if (w_Wr && !w_Pop) begin
      w_Count_Next = r_Count + 1'b1;
    end else if (!w_Wr && w_Pop) begin
      w_Count_Next = r_Count - 1'b1;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (w_Wr) begin
      r_Mem[r_Wr_Ptr] <= i_Tx_Byte;
    end
    r_Rd_Data <= r_Mem[r_Rd_Ptr];
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Wr_Ptr       <= '0;
      r_Rd_Ptr       <= '0;
      r_Count        <= '0;
      r_Ready        <= 1'b1;
      r_Was_Nonempty <= 1'b0;
    end else begin
      if (w_Wr) begin
        r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
      end
      if (w_Pop) begin
        r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
      end
      r_Count        <= w_Count_Next;
      r_Ready        <= (w_Count_Next != LP_FULL);
      r_Was_Nonempty <= (r_Count != '0);
    end
  end

  // ---------------- Transmit FSM ----------------
  t_state     r_State;
  logic [7:0] r_Clk_Cnt;
  logic [2:0] r_Bit_Idx;
  logic [7:0] r_Shift;
  logic       r_Serial;
  logic       r_Active;
  logic       r_Done;

  t_state     w_State_Next;
  logic [7:0] w_Clk_Cnt_Next;
  logic [2:0] w_Bit_Idx_Next;
  logic [7:0] w_Shift_Next;
  logic       w_Serial_Next;
  logic       w_Active_Next;
  logic       w_Done_Next;
  logic       w_Bit_End;
  logic [2:0] w_Idx_Inc;

  assign w_Bit_End = (r_Clk_Cnt == LP_BIT_LAST);
  assign w_Idx_Inc = r_Bit_Idx + 3'd1;

  always_comb begin
    w_State_Next   = r_State;
    w_Clk_Cnt_Next = r_Clk_Cnt;
    w_Bit_Idx_Next = r_Bit_Idx;
    w_Shift_Next   = r_Shift;
    w_Serial_Next  = r_Serial;
    w_Active_Next  = r_Active;
    w_Done_Next    = 1'b0;
    w_Pop          = 1'b0;
    case (r_State)
      S_IDLE: begin
        w_Serial_Next  = 1'b1;
        w_Active_Next  = 1'b0;
        w_Clk_Cnt_Next = '0;
        w_Bit_Idx_Next = '0;
        if (w_Can_Pop) begin
          w_Pop         = 1'b1;
          w_Shift_Next  = r_Rd_Data;
          w_Serial_Next = 1'b0;
          w_Active_Next = 1'b1;
          w_State_Next  = S_START;
        end
      end
      S_START: begin
        if (w_Bit_End) begin
          w_Clk_Cnt_Next = '0;
          w_Bit_Idx_Next = '0;
          w_Serial_Next  = r_Shift[0];
          w_State_Next   = S_DATA;
        end else begin
          w_Clk_Cnt_Next = r_Clk_Cnt + 8'd1;
        end
      end
      S_DATA: begin
        if (w_Bit_End) begin
          w_Clk_Cnt_Next = '0;
          if (r_Bit_Idx == 3'd7) begin
            w_Serial_Next = 1'b1;
            w_State_Next  = S_STOP;
          end else begin
            w_Bit_Idx_Next = w_Idx_Inc;
            w_Serial_Next  = r_Shift[w_Idx_Inc];
          end
        end else begin
          w_Clk_Cnt_Next = r_Clk_Cnt + 8'd1;
        end
      end
      S_STOP: begin
        if (w_Bit_End) begin
          w_Clk_Cnt_Next = '0;
          w_Active_Next  = 1'b0;
          w_Done_Next    = 1'b1;
          w_State_Next   = S_CLEANUP;
        end else begin
          w_Clk_Cnt_Next = r_Clk_Cnt + 8'd1;
        end
      end
      S_CLEANUP: begin
        w_Serial_Next = 1'b1;
        w_State_Next  = S_IDLE;
      end
      default: begin
        w_Serial_Next  = 1'b1;
        w_Active_Next  = 1'b0;
        w_Clk_Cnt_Next = '0;
        w_Bit_Idx_Next = '0;
        w_State_Next   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State   <= S_IDLE;
      r_Clk_Cnt <= '0;
      r_Bit_Idx <= '0;
      r_Shift   <= '0;
      r_Serial  <= 1'b1;
      r_Active  <= 1'b0;
      r_Done    <= 1'b0;
    end else begin
      r_State   <= w_State_Next;
      r_Clk_Cnt <= w_Clk_Cnt_Next;
      r_Bit_Idx <= w_Bit_Idx_Next;
      r_Shift   <= w_Shift_Next;
      r_Serial  <= w_Serial_Next;
      r_Active  <= w_Active_Next;
      r_Done    <= w_Done_Next;
    end
  end

  assign o_Tx_Ready   = r_Ready;
  assign o_Tx_Serial  = r_Serial;
  assign o_Tx_Active  = r_Active;
  assign o_Tx_Done    = r_Done;
  assign o_Fifo_Count = r_Count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CPB6  = 217;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       dv;
  logic [7:0] tx_byte;
  logic       ready, serial, active, done;
  logic [2:0] fcount;

  logic       dv2;
  logic [7:0] byte2;
  logic       ready2, serial2, active2, done2;
  logic [2:0] fcount2;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv), .i_Tx_Byte(tx_byte),
    .o_Tx_Ready(ready), .o_Tx_Serial(serial), .o_Tx_Active(active),
    .o_Tx_Done(done), .o_Fifo_Count(fcount)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB6), .FIFO_DEPTH(DEPTH)) dut217 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv2), .i_Tx_Byte(byte2),
    .o_Tx_Ready(ready2), .o_Tx_Serial(serial2), .o_Tx_Active(active2),
    .o_Tx_Done(done2), .o_Fifo_Count(fcount2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (queue + frame timeline) ----------------
  logic [7:0] m_q[$];
  int         m_acc[$];
  int         m_fstart = -1;
  logic [7:0] m_fbyte  = 8'h00;
  int         m_free   = 0;
  logic [7:0] exp_rx[$];

  // serial-line decoder acting as a loopback receiver
  int         mon_start = -1;
  logic [7:0] mon_byte  = 8'h00;
  logic       mon_prev  = 1'b1;
  logic [7:0] rx_log[$];
  int         starts[$];

  task automatic model_reset();
    m_q.delete();
    m_acc.delete();
    m_fstart  = -1;
    m_free    = 0;
    exp_rx.delete();
    mon_start = -1;
    mon_prev  = 1'b1;
  endtask

  task automatic model_step();
    logic wr, pop;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    wr  = dv && (m_q.size() < DEPTH);
    pop = (cyc >= m_free) && (m_q.size() > 0) && (cyc >= m_acc[0] + 2);
    if (pop) begin
      m_fbyte  = m_q.pop_front();
      void'(m_acc.pop_front());
      m_fstart = cyc;
      m_free   = cyc + 10 * CPB + 2;
      exp_rx.push_back(m_fbyte);
    end
    if (wr) begin
      m_q.push_back(tx_byte);
      m_acc.push_back(cyc);
      $display("cycle %0d: accepted byte %02h (queued %0d)", cyc, tx_byte, m_q.size());
    end
  endtask

  task automatic check_cycle();
    int d, slot;
    logic e_serial, e_active, e_done;
    d        = cyc - m_fstart;
    e_active = (m_fstart >= 0) && (d >= 0) && (d < 10 * CPB);
    e_done   = (m_fstart >= 0) && (d == 10 * CPB);
    e_serial = 1'b1;
    if (e_active) begin
      slot = d / CPB;
      if (slot == 0)      e_serial = 1'b0;
      else if (slot <= 8) e_serial = m_fbyte[slot-1];
    end
    check("cycle_outputs", {serial, active, done, ready, fcount},
          {e_serial, e_active, e_done, (m_q.size() != DEPTH), 3'(m_q.size())});
  endtask

  task automatic monitor();
    int d, k;
    if (!rst_n) begin
      mon_start = -1;
      mon_prev  = 1'b1;
      return;
    end
    if (mon_start < 0) begin
      if (mon_prev && !serial) begin
        mon_start = cyc;
        starts.push_back(cyc);
      end
    end else begin
      d = cyc - mon_start;
      if (d % CPB == CPB / 2) begin
        k = d / CPB;
        if (k >= 1 && k <= 8) mon_byte[k-1] = serial;
        if (k == 9) begin
          check("stop_bit", serial, 1'b1);
          rx_log.push_back(mon_byte);
          $display("cycle %0d: received byte %02h", cyc, mon_byte);
          if (exp_rx.size() == 0) check("rx_unexpected", mon_byte, 9'h100);
          else check("rx_byte", mon_byte, exp_rx.pop_front());
          mon_start = -1;
        end
      end
    end
    mon_prev = serial;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_cycle();
    monitor();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_q.size() != 0 || cyc < m_free) && n < 3000) begin
      tick();
      n++;
    end
    check("idle_reached", (n < 3000), 1'b1);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [7:0] data;
    logic [9:0] line;     // bit k = line level in bit slot k (start..stop)
    int         active_cycles;
    int         done_pulses;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] burst[4];
  logic [9:0] line81;

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h55, 10'b10_1010_1010, 40, 1};
    vecs[1] = '{8'h00, 10'b10_0000_0000, 40, 1};
    vecs[2] = '{8'hFF, 10'b11_1111_1110, 40, 1};
    vecs[3] = '{8'hA5, 10'b11_0100_1010, 40, 1};
    vecs[4] = '{8'h3C, 10'b10_0111_1000, 40, 1};
    vecs[5] = '{8'h81, 10'b11_0000_0010, 40, 1};
    burst   = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    line81  = 10'b11_0000_0010;

    rst_n = 1'b0; dv = 1'b0; tx_byte = 8'h00; dv2 = 1'b0; byte2 = 8'h00;
    repeat (3) tick();
    check("reset_state", {serial, active, done, ready, fcount}, 7'b1_0_0_1_000);
    rst_n = 1'b1;
    repeat (3) tick();

    // single frames from the table
    foreach (vecs[i]) begin
      logic [9:0] got;
      logic       s1, s2;
      int         act_n, done_n;
      got = '0; s1 = 1'b0; s2 = 1'b0; act_n = 0; done_n = 0;
      wait_idle();
      dv = 1'b1; tx_byte = vecs[i].data;
      tick();
      dv = 1'b0;
      for (int j = 1; j <= 44; j++) begin
        tick();
        if (j == 1) s1 = serial;
        if (j == 2) s2 = serial;
        if (active) act_n++;
        if (done) done_n++;
        if (j >= 2 && j < 42 && (j - 2) % CPB == CPB / 2) got[(j - 2) / CPB] = serial;
      end
      check("start_latency", {s1, s2}, 2'b10);
      check("frame_bits", got, vecs[i].line);
      check("active_cycles", act_n, vecs[i].active_cycles);
      check("done_pulses", done_n, vecs[i].done_pulses);
    end

    // four back-to-back writes
    begin
      int base_rx, base_st, peak;
      logic rdy_all;
      wait_idle();
      base_rx = rx_log.size(); base_st = starts.size(); peak = 0; rdy_all = 1'b1;
      for (int i = 0; i < 4; i++) begin
        dv = 1'b1; tx_byte = burst[i];
        tick();
        if (int'(fcount) > peak) peak = int'(fcount);
        rdy_all &= ready;
      end
      dv = 1'b0;
      wait_idle();
      check("burst_ready_held", rdy_all, 1'b1);
      check("burst_count_peak", peak, 3);
      check("burst_frames", rx_log.size() - base_rx, 4);
      for (int i = 0; i < 4 && base_rx + i < rx_log.size(); i++)
        check("burst_loopback", rx_log[base_rx + i], burst[i]);
      for (int i = 1; i < 4 && base_st + i < starts.size(); i++)
        check("start_spacing", starts[base_st + i] - starts[base_st + i - 1], 10 * CPB + 2);
    end

    // six writes: FIFO fills, sixth byte dropped
    begin
      int   base_rx;
      logic rdy[6];
      logic [2:0] cnt[6];
      wait_idle();
      base_rx = rx_log.size();
      for (int i = 0; i < 6; i++) begin
        dv = 1'b1; tx_byte = 8'(8'h11 * (i + 1));
        tick();
        rdy[i] = ready; cnt[i] = fcount;
      end
      dv = 1'b0;
      check("fill_ready_before_full", rdy[3], 1'b1);
      check("fill_ready_full", rdy[4], 1'b0);
      check("fill_count_full", cnt[4], 3'd4);
      check("fill_count_after_drop", cnt[5], 3'd4);
      wait_idle();
      check("fill_frames", rx_log.size() - base_rx, 5);
      if (rx_log.size() > 0) check("fill_last_byte", rx_log[rx_log.size() - 1], 8'h55);
    end

    // full FIFO, DV held across the pop edge
    begin
      int   base_rx, n;
      logic [2:0] prev;
      logic hit;
      wait_idle();
      base_rx = rx_log.size();
      for (int i = 0; i < 5; i++) begin
        dv = 1'b1; tx_byte = 8'(8'hA0 + i);
        tick();
      end
      tx_byte = 8'hC3; n = 0; hit = 1'b0; prev = fcount;
      while (!hit && n < 100) begin
        tick();
        n++;
        if (prev == 3'd4 && fcount == 3'd3) hit = 1'b1;
        prev = fcount;
      end
      check("pop_edge_found", hit, 1'b1);
      check("pop_edge_ready", ready, 1'b1);
      tx_byte = 8'h3D;
      tick();
      dv = 1'b0;
      check("refill_count", fcount, 3'd4);
      check("refill_ready", ready, 1'b0);
      wait_idle();
      check("refill_frames", rx_log.size() - base_rx, 6);
      if (rx_log.size() > 0) check("refill_last_byte", rx_log[rx_log.size() - 1], 8'h3D);
    end

    // reset during data bit 3 with two bytes queued
    begin
      int   base_rx, n, busy;
      wait_idle();
      base_rx = rx_log.size();
      for (int i = 0; i < 3; i++) begin
        dv = 1'b1; tx_byte = 8'(8'hF0 + i);
        tick();
      end
      dv = 1'b0; n = 0;
      while (!(mon_start >= 0 && cyc - mon_start == 4 * CPB + 1) && n < 100) begin
        tick();
        n++;
      end
      check("reach_bit3", (n < 100), 1'b1);
      check("queued_before_reset", fcount, 3'd2);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_cycle();
      check("rst_line_high", serial, 1'b1);
      check("rst_state", {active, done, ready, fcount}, 6'b0_0_1_000);
      repeat (3) tick();
      rst_n = 1'b1;
      busy = 0;
      for (int i = 0; i < 120; i++) begin
        tick();
        if (active || done || !serial) busy++;
      end
      check("quiet_after_reset", busy, 0);
      check("no_rx_after_reset", rx_log.size() - base_rx, 0);
    end

    // long bit period: 0x81 on the 217-clock instance
    begin
      logic s1, s2;
      int   bad, act_bad;
      dv2 = 1'b1; byte2 = 8'h81;
      tick();
      dv2 = 1'b0;
      tick(); s1 = serial2;
      tick(); s2 = serial2;
      check("start_latency_217", {s1, s2}, 2'b10);
      for (int k = 0; k < 10; k++) begin
        bad = 0; act_bad = 0;
        for (int c = 0; c < CPB6; c++) begin
          if (serial2 !== line81[k]) bad++;
          if (active2 !== 1'b1) act_bad++;
          tick();
        end
        check("bit_width_217", bad, 0);
        check("active_217", act_bad, 0);
      end
      check("done_217", {done2, active2, serial2}, 3'b101);
      tick();
      check("done_clear_217", done2, 1'b0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      dv      = ($urandom_range(0, (i < 1200) ? 7 : 1) == 0);
      tx_byte = 8'($urandom);
      tick();
    end
    dv = 1'b0;
    wait_idle();
    repeat (5) tick();
    check("scoreboard_drained", exp_rx.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
